// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: powers up and initialises an 8-bit HD44780-style LCD, then
// shares its write bus round-robin between two requesters with proper timing.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   req0/1, rs0/1, data0/1 per-requester write request, held until ack
//   ack0/1                one-cycle pulse when that requester's word is latched
//   ready                 high once the init sequence has completed
//   lcd_rs, lcd_rw,       LCD pins (lcd_rw is always 0, write only)
//   lcd_en, lcd_data
module lcd_bus_arbiter #(
    parameter int unsigned T_PWRUP = 5400000,
    parameter int unsigned T_SU    = 4,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_CMD   = 2700,
    parameter int unsigned T_CLR   = 108000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    typedef enum logic [2:0] {
        PWRUP,
        IDLE,
        SETUP,
        ENABLE,
        WAIT
    } state_t;

    // Counter reload values: a timed state lasts (reload + 1) cycles.
    localparam logic [31:0] PWRUP_M1 = 32'(T_PWRUP - 1);
    localparam logic [31:0] SU_M1    = 32'(T_SU - 1);
    localparam logic [31:0] EN_M1    = 32'(T_EN - 1);
    localparam logic [31:0] CMD_M1   = 32'(T_CMD - 1);
    localparam logic [31:0] CLR_M1   = 32'(T_CLR - 1);

    localparam logic [2:0] INIT_DONE = 3'd4;

    state_t      state;
    state_t      state_n;
    logic [31:0] cnt;
    logic [31:0] cnt_n;
    logic [2:0]  init_idx;
    logic [2:0]  init_idx_n;
    logic        last;        // 1: requester 1 was granted last
    logic        last_n;
    logic        ready_n;
    logic        ack0_n;
    logic        ack1_n;
    logic        en_n;
    logic        rs_n;
    logic [7:0]  data_n;

    logic [7:0]  init_word;
    logic        slow_cmd;
    logic        grant0;
    logic        grant1;

    always_comb begin
        init_word = 8'h38;
        case (init_idx)
            3'd0:    init_word = 8'h38;
            3'd1:    init_word = 8'h01;
            3'd2:    init_word = 8'h0C;
            3'd3:    init_word = 8'h06;
            default: init_word = 8'h38;
        endcase
    end

    // Clear and home commands need the long execution time.
    assign slow_cmd = !lcd_rs &&
                      (lcd_data == 8'h01 ||
                       lcd_data == 8'h02 ||
                       lcd_data == 8'h03);

    // On a tie, the requester not granted last wins.
    assign grant0 = req0 && (!req1 || last);
    assign grant1 = req1 && !grant0;

    assign lcd_rw = 1'b0;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        init_idx_n = init_idx;
        last_n     = last;
        ready_n    = ready;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        en_n       = lcd_en;
        rs_n       = lcd_rs;
        data_n     = lcd_data;

        unique case (state)
            PWRUP: begin
                if (cnt == 32'd0) begin
                    state_n    = IDLE;
                    init_idx_n = 3'd0;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            IDLE: begin
                if (init_idx != INIT_DONE) begin
                    rs_n       = 1'b0;
                    data_n     = init_word;
                    init_idx_n = init_idx + 3'd1;
                    state_n    = SETUP;
                    cnt_n      = SU_M1;
                end else if (grant0 || grant1) begin
                    rs_n    = grant0 ? rs0 : rs1;
                    data_n  = grant0 ? data0 : data1;
                    ack0_n  = grant0;
                    ack1_n  = grant1;
                    last_n  = grant1;
                    state_n = SETUP;
                    cnt_n   = SU_M1;
                end
            end
            SETUP: begin
                if (cnt == 32'd0) begin
                    state_n = ENABLE;
                    en_n    = 1'b1;
                    cnt_n   = EN_M1;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            ENABLE: begin
                if (cnt == 32'd0) begin
                    state_n = WAIT;
                    en_n    = 1'b0;
                    cnt_n   = slow_cmd ? CLR_M1 : CMD_M1;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            WAIT: begin
                if (cnt == 32'd0) begin
                    state_n = IDLE;
                    if (init_idx == INIT_DONE) begin
                        ready_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            default: begin
                state_n = PWRUP;
                cnt_n   = PWRUP_M1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PWRUP;
            cnt      <= PWRUP_M1;
            init_idx <= 3'd0;
            last     <= 1'b1;
            ready    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            init_idx <= init_idx_n;
            last     <= last_n;
            ready    <= ready_n;
            ack0     <= ack0_n;
            ack1     <= ack1_n;
            lcd_en   <= en_n;
            lcd_rs   <= rs_n;
            lcd_data <= data_n;
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: scoreboard bench for lcd_bus_arbiter; stimulus pushes
// expected LCD words, a monitor checks each enable pulse against the queue.
module tb_lcd_bus_arbiter;

    localparam int T_PWRUP = 20;
    localparam int T_SU    = 2;
    localparam int T_EN    = 4;
    localparam int T_CMD   = 6;
    localparam int T_CLR   = 30;

    // en-low samples between pulses when the next word is granted at once
    localparam int GAP_CMD = T_CMD + 1 + T_SU;
    localparam int GAP_CLR = T_CLR + 1 + T_SU;
    // en-low samples from reset release to the first init pulse
    localparam int GAP_PWR = T_PWRUP + T_SU;
    localparam int MIN_PER = T_SU + T_EN + T_CMD + 1;
    localparam int INIT    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       rs0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       req1 = 1'b0;
    logic       rs1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ack0;
    logic       ack1;
    logic       ready;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    lcd_bus_arbiter #(
        .T_PWRUP(T_PWRUP),
        .T_SU(T_SU),
        .T_EN(T_EN),
        .T_CMD(T_CMD),
        .T_CLR(T_CLR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .rs0(rs0),
        .data0(data0),
        .req1(req1),
        .rs1(rs1),
        .data1(data1),
        .ack0(ack0),
        .ack1(ack1),
        .ready(ready),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_en(lcd_en),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         who;   // 0/1 requester, INIT for init words
        int         gap;   // exact en-low samples before rise, 0 = unchecked
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;

    function automatic void chk(string name, bit ok, int act, int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void eq(string name, int act, int exp);
        chk(name, act == exp, act, exp);
    endfunction

    task automatic push(input logic r, input logic [7:0] d,
                        input int who, input int gap, input logic rdy);
        exp_t e;
        e.rs = r;
        e.data = d;
        e.who = who;
        e.gap = gap;
        e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int   smp = 0;
    int   lowcnt = 0;
    int   highcnt = 0;
    int   nack = 0;
    int   ack_who = 0;
    int   last_ack = -1;
    bit   prev_en = 1'b0;
    exp_t cur;

    always begin
        @(posedge clk);
        #1;
        smp++;
        if (reset) begin
            lowcnt = 0;
            highcnt = 0;
            nack = 0;
            last_ack = -1;
            prev_en = 1'b0;
        end else begin
            if (ack0 || ack1) begin
                eq("ack_while_ready", int'(ready), 1);
                eq("ack_onehot", int'(ack0 & ack1), 0);
                if (last_ack >= 0)
                    chk("ack_spacing", (smp - last_ack) >= MIN_PER,
                        smp - last_ack, MIN_PER);
                last_ack = smp;
                ack_who = ack1 ? 1 : 0;
                nack++;
            end
            if (lcd_en && !prev_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_en_pulse", 1'b0, int'(lcd_data), -1);
                end else begin
                    cur = exp_q.pop_front();
                    eq("word_rs", int'(lcd_rs), int'(cur.rs));
                    eq("word_data", int'(lcd_data), int'(cur.data));
                    eq("word_rw", int'(lcd_rw), 0);
                    eq("word_ready", int'(ready), int'(cur.rdy));
                    if (cur.gap != 0)
                        eq("en_low_gap", lowcnt, cur.gap);
                    if (cur.who == INIT) begin
                        eq("init_no_ack", nack, 0);
                    end else begin
                        eq("grant_ack_count", nack, 1);
                        eq("grant_winner", ack_who, cur.who);
                        eq("ack_to_en", smp - last_ack, T_SU);
                    end
                end
                nack = 0;
                lowcnt = 0;
                highcnt = 1;
            end else if (lcd_en) begin
                highcnt++;
            end else if (prev_en) begin
                eq("en_width", highcnt, T_EN);
                lowcnt = 1;
            end else begin
                lowcnt++;
            end
            prev_en = lcd_en;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ack(input int who, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = (who == 0) ? ack0 : ack1;
        end
        chk(name, seen, int'(seen), 1);
    endtask

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = ready;
        end
        chk(name, seen, int'(seen), 1);
    endtask

    task automatic wait_en(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = lcd_en;
        end
        chk(name, seen, int'(seen), 1);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, INIT, GAP_PWR, 1'b0);
        push(1'b0, 8'h01, INIT, GAP_CMD, 1'b0);
        push(1'b0, 8'h0C, INIT, GAP_CLR, 1'b0);
        push(1'b0, 8'h06, INIT, GAP_CMD, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        eq("rst_en", int'(lcd_en), 0);
        eq("rst_rs", int'(lcd_rs), 0);
        eq("rst_data", int'(lcd_data), 0);
        eq("rst_rw", int'(lcd_rw), 0);
        eq("rst_ack0", int'(ack0), 0);
        eq("rst_ack1", int'(ack1), 0);
        eq("rst_ready", int'(ready), 0);

        push_init();
        reset = 1'b0;
        wait_ready("ready_after_init");

        // both held: alternate starting with requester 0
        push(1'b1, 8'h41, 0, 0, 1'b1);
        push(1'b1, 8'h42, 1, GAP_CMD, 1'b1);
        push(1'b1, 8'h41, 0, GAP_CMD, 1'b1);
        push(1'b1, 8'h42, 1, GAP_CMD, 1'b1);
        rs0 = 1'b1;
        data0 = 8'h41;
        rs1 = 1'b1;
        data1 = 8'h42;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_ack(0, "tie_ack_0a");
        wait_ack(1, "tie_ack_1a");
        wait_ack(0, "tie_ack_0b");
        wait_ack(1, "tie_ack_1b");

        // clear command then a normal command, back to back
        req0 = 1'b0;
        rs1 = 1'b0;
        data1 = 8'h01;
        push(1'b0, 8'h01, 1, GAP_CMD, 1'b1);
        push(1'b0, 8'hC0, 1, GAP_CLR, 1'b1);
        wait_ack(1, "clear_ack");
        data1 = 8'hC0;
        wait_ack(1, "c0_ack");

        // single data write 'K'
        req1 = 1'b0;
        rs0 = 1'b1;
        data0 = 8'h4B;
        req0 = 1'b1;
        push(1'b1, 8'h4B, 0, GAP_CMD, 1'b1);
        wait_ack(0, "k_ack");
        req0 = 1'b0;

        // word cut short by reset during its enable pulse
        rs1 = 1'b1;
        data1 = 8'h55;
        req1 = 1'b1;
        push(1'b1, 8'h55, 1, GAP_CMD, 1'b1);
        wait_ack(1, "pre_reset_ack");
        req1 = 1'b0;
        wait_en("en_before_reset");
        reset = 1'b1;
        #1;
        eq("midrst_en", int'(lcd_en), 0);
        eq("midrst_data", int'(lcd_data), 0);
        eq("midrst_rs", int'(lcd_rs), 0);
        eq("midrst_ready", int'(ready), 0);
        eq("midrst_ack1", int'(ack1), 0);

        // request pending through power-up is served right after init
        rs0 = 1'b1;
        data0 = 8'h5A;
        req0 = 1'b1;
        push_init();
        push(1'b1, 8'h5A, 0, GAP_CMD, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_ack(0, "pwrup_req_ack");
        req0 = 1'b0;

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
            @(negedge clk);
        repeat (10) @(negedge clk);
        eq("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
